// File: rtl/minterm_sweep.sv
// minterm_sweep: streams every input vector of an N_IN-input truth table with its function value.
// Define MINTERM_SWEEP_COUNT_EN to build the ones_count counter; otherwise ones_count is tied to 0.
module minterm_sweep #(
   parameter int N_IN = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 tt_load,
   input  logic [2**N_IN-1:0]   tt_data,
   input  logic                 start,
   input  logic                 gray_mode,
   input  logic                 abort,
   input  logic                 out_ready,
   output logic                 out_valid,
   output logic [N_IN-1:0]      out_vec,
   output logic                 out_f,
   output logic                 busy,
   output logic                 done,
   output logic [N_IN:0]        ones_count
);
   localparam int W = 1 << N_IN;
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t state_q, state_d;
   logic [W-1:0] tt_q, tt_d, tt_use;
   logic [N_IN-1:0] idx_q, idx_d, idx_nx, vec_nx, out_vec_q, out_vec_d;
   logic gray_q, gray_d, out_valid_q, out_valid_d, out_f_q, out_f_d;
   logic busy_q, busy_d, done_q, done_d, xfer, last;
   assign idx_nx = idx_q + 1'b1;
   assign vec_nx = gray_q ? idx_nx ^ (idx_nx >> 1) : idx_nx;
   assign xfer   = (state_q == RUN) && out_ready;
   assign last   = &idx_q;
   always_comb begin
      state_d     = state_q;
      tt_d        = tt_q;
      idx_d       = idx_q;
      gray_d      = gray_q;
      out_valid_d = out_valid_q;
      out_vec_d   = out_vec_q;
      out_f_d     = out_f_q;
      tt_use      = tt_load ? tt_data : tt_q;
      case (state_q)
         IDLE: begin
            tt_d = tt_use;
            if (start) begin
               state_d     = RUN;
               gray_d      = gray_mode;
               idx_d       = '0;
               out_valid_d = 1'b1;
               out_vec_d   = '0;
               out_f_d     = tt_use[0];
            end
         end
         RUN: begin
            // the final transfer leaves idx and the sample at the last vector
            if (xfer && !last) begin
               idx_d     = idx_nx;
               out_vec_d = vec_nx;
               out_f_d   = tt_q[vec_nx];
            end
            if (abort) begin
               state_d     = IDLE;
               out_valid_d = 1'b0;
            end else if (xfer && last) begin
               state_d     = DONE;
               out_valid_d = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
      busy_d = state_d != IDLE;
      done_d = state_d == DONE;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         tt_q        <= '0;
         idx_q       <= '0;
         gray_q      <= 1'b0;
         out_valid_q <= 1'b0;
         out_vec_q   <= '0;
         out_f_q     <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         tt_q        <= tt_d;
         idx_q       <= idx_d;
         gray_q      <= gray_d;
         out_valid_q <= out_valid_d;
         out_vec_q   <= out_vec_d;
         out_f_q     <= out_f_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end
   assign out_valid = out_valid_q;
   assign out_vec   = out_vec_q;
   assign out_f     = out_f_q;
   assign busy      = busy_q;
   assign done      = done_q;
`ifdef MINTERM_SWEEP_COUNT_EN
   logic [N_IN:0] cnt_q, cnt_d;
   always_comb begin
      cnt_d = cnt_q;
      if (state_q == IDLE && start) cnt_d = '0;
      else if (xfer) cnt_d = cnt_q + (N_IN+1)'(out_f_q);
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else cnt_q <= cnt_d;
   end
   assign ones_count = cnt_q;
`else
   assign ones_count = '0;
`endif
endmodule

// File: tb/tb_minterm_sweep.sv
// tb_minterm_sweep: randomized scenario bench for minterm_sweep against a vector-list reference model.
// Expected ones_count follows MINTERM_SWEEP_COUNT_EN the same way the design does.
module tb_minterm_sweep;
   localparam int N = 4;
   logic clk = 1'b0, rst_n = 1'b0, tt_load = 1'b0, start = 1'b0, gray_mode = 1'b0;
   logic abort = 1'b0, out_ready = 1'b0;
   logic [15:0] tt_data = '0;
   logic out_valid, out_f, busy, done;
   logic [N-1:0] out_vec;
   logic [N:0] ones_count;
   int tests = 0, fails = 0;

   minterm_sweep #(.N_IN(N)) dut (
      .clk(clk), .rst_n(rst_n), .tt_load(tt_load), .tt_data(tt_data), .start(start),
      .gray_mode(gray_mode), .abort(abort), .out_ready(out_ready), .out_valid(out_valid),
      .out_vec(out_vec), .out_f(out_f), .busy(busy), .done(done), .ones_count(ones_count)
   );

   always #5 clk = ~clk;

   function automatic int exp_ones(input int c);
`ifdef MINTERM_SWEEP_COUNT_EN
      return c;
`else
      return 0;
`endif
   endfunction

   // mode: 0 always ready, 1 random ready, 2 three-cycle stall at vector index 5
   task automatic do_sweep(input logic [15:0] tbl, input logic load, input logic g, input int mode,
                           input int abort_at, input int rst_at, input logic noise);
      int k = 0, cnt = 0, stall = 0, cyc = 0, vec, ef;
      logic rdy;
      tt_load = load; tt_data = tbl; gray_mode = g; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; tt_load = 1'b0; gray_mode = ~g;
      while (k < 16 && cyc < 200) begin
         cyc++;
         vec = g ? (k ^ (k >> 1)) : k;
         ef = int'(tbl[vec]);
         tests++;
         if (out_valid !== 1'b1 || busy !== 1'b1 || done !== 1'b0) begin
            fails++; $display("FAIL run_ctl k=%0d valid/busy/done got %b%b%b want 110", k, out_valid, busy, done);
         end
         tests++;
         if (out_vec !== vec[N-1:0]) begin
            fails++; $display("FAIL out_vec k=%0d got %0d want %0d", k, out_vec, vec);
         end
         tests++;
         if (out_f !== ef[0]) begin
            fails++; $display("FAIL out_f k=%0d vec=%0d got %b want %0d", k, vec, out_f, ef);
         end
         tests++;
         if (ones_count !== (N+1)'(exp_ones(cnt))) begin
            fails++; $display("FAIL ones_run k=%0d got %0d want %0d", k, ones_count, exp_ones(cnt));
         end
         if (k == rst_at) begin
            rst_n = 1'b0; #1;
            tests++;
            if ({out_valid, out_vec, out_f, busy, done, ones_count} !== '0) begin
               fails++; $display("FAIL async_reset got v=%b vec=%0d f=%b b=%b d=%b oc=%0d want all 0",
                                 out_valid, out_vec, out_f, busy, done, ones_count);
            end
            rst_n = 1'b1; out_ready = 1'b1; tt_load = 1'b0; start = 1'b0;
            @(posedge clk); #1;
            tests++;
            if (out_valid !== 1'b0 || busy !== 1'b0) begin
               fails++; $display("FAIL post_reset_idle valid/busy got %b%b want 00", out_valid, busy);
            end
            return;
         end
         rdy = mode == 0 ? 1'b1 : mode == 1 ? 1'($urandom % 2) : !(k == 5 && stall < 3);
         if (mode == 2 && !rdy) stall++;
         if (k == abort_at) begin
            abort = 1'b1;
            rdy = k == 15;
         end
         if (noise) begin
            tt_load = 1'b1; tt_data = ($urandom % 2) ? 16'hFFFF : 16'($urandom);
            start = 1'($urandom % 2);
         end
         out_ready = rdy;
         @(posedge clk); #1;
         if (rdy) begin
            cnt += ef; k++;
         end
         if (abort) begin
            abort = 1'b0; tt_load = 1'b0; start = 1'b0;
            tests++;
            if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
               fails++; $display("FAIL abort_idle valid/busy/done got %b%b%b want 000", out_valid, busy, done);
            end
            tests++;
            if (ones_count !== (N+1)'(exp_ones(cnt))) begin
               fails++; $display("FAIL abort_ones got %0d want %0d", ones_count, exp_ones(cnt));
            end
            @(posedge clk); #1;
            tests++;
            if (done !== 1'b0 || out_valid !== 1'b0) begin
               fails++; $display("FAIL abort_no_done done/valid got %b%b want 00", done, out_valid);
            end
            return;
         end
      end
      tt_load = 1'b0; start = 1'b0;
      tests++;
      if (k != 16) begin
         fails++; $display("FAIL sweep_timeout transfers got %0d want 16", k);
      end
      tests++;
      if (out_valid !== 1'b0 || busy !== 1'b1 || done !== 1'b1) begin
         fails++; $display("FAIL done_state valid/busy/done got %b%b%b want 011", out_valid, busy, done);
      end
      tests++;
      if (ones_count !== (N+1)'(exp_ones(cnt))) begin
         fails++; $display("FAIL done_ones got %0d want %0d", ones_count, exp_ones(cnt));
      end
      abort = noise; start = noise;
      @(posedge clk); #1;
      abort = 1'b0; start = 1'b0;
      tests++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
         fails++; $display("FAIL after_done valid/busy/done got %b%b%b want 000", out_valid, busy, done);
      end
      tests++;
      if (ones_count !== (N+1)'(exp_ones(cnt))) begin
         fails++; $display("FAIL ones_hold got %0d want %0d", ones_count, exp_ones(cnt));
      end
   endtask

   task automatic test_reset;
      #2;
      tests++;
      if ({out_valid, out_vec, out_f, busy, done, ones_count} !== '0) begin
         fails++; $display("FAIL reset_state got v=%b vec=%0d f=%b b=%b d=%b oc=%0d want all 0",
                           out_valid, out_vec, out_f, busy, done, ones_count);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_idle_abort;
      abort = 1'b1; out_ready = 1'b1;
      repeat (3) begin
         @(posedge clk); #1;
         tests++;
         if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            fails++; $display("FAIL idle_abort valid/busy/done got %b%b%b want 000", out_valid, busy, done);
         end
      end
      abort = 1'b0;
   endtask

   task automatic test_binary;       do_sweep(16'hDF03, 1'b1, 1'b0, 0, -1, -1, 1'b0); endtask
   task automatic test_gray;         do_sweep(16'hDF03, 1'b1, 1'b1, 0, -1, -1, 1'b0); endtask
   task automatic test_backpressure; do_sweep(16'hDF03, 1'b1, 1'b0, 2, -1, -1, 1'b0); endtask
   task automatic test_abort;        do_sweep(16'hDF03, 1'b1, 1'b0, 0, 6, -1, 1'b0); endtask
   task automatic test_abort_last;   do_sweep(16'hDF03, 1'b1, 1'b1, 1, 15, -1, 1'b0); endtask
   task automatic test_load_in_run;  do_sweep(16'hDF03, 1'b1, 1'b0, 1, -1, -1, 1'b1); endtask

   task automatic test_reset_mid;
      do_sweep(16'hDF03, 1'b1, 1'b0, 0, -1, 7, 1'b0);
      do_sweep(16'h0000, 1'b0, 1'($urandom % 2), 1, -1, -1, 1'b0);
   endtask

   task automatic test_random;
      for (int i = 0; i < 6; i++)
         do_sweep(16'($urandom), 1'b1, 1'($urandom % 2), 1, -1, -1, 1'b1);
   endtask

   initial begin
      test_reset;
      test_idle_abort;
      test_binary;
      test_gray;
      test_backpressure;
      test_abort;
      test_abort_last;
      test_load_in_run;
      test_reset_mid;
      test_random;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/minterm_sweep.md
MINTERM_SWEEP -- requirements
Module: minterm_sweep

Interface
REQ-001 The block SHALL have parameter N_IN, default 4, the number of function inputs (legal range 2..8).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, the reset: asynchronous and active-low.
REQ-004 The block SHALL have port tt_load, input, 1, a request to capture tt_data into the truth-table register.
REQ-005 The block SHALL have port tt_data, input, 2**N_IN, the truth table: bit k is F for input vector k.
REQ-006 The block SHALL have port start, input, 1, a request to begin a sweep of all 2**N_IN input vectors.
REQ-007 The block SHALL have port gray_mode, input, 1, sweep order selector: 0 is binary ascending, 1 is reflected Gray code.
REQ-008 The block SHALL have port abort, input, 1, a request to terminate the current sweep.
REQ-009 The block SHALL have port out_ready, input, 1, the downstream-ready half of the output handshake.
REQ-010 The block SHALL have port out_valid, output, 1, meaning out_vec/out_f hold a valid sample.
REQ-011 The block SHALL have port out_vec, output, N_IN, the current input vector (MSB = first variable).
REQ-012 The block SHALL have port out_f, output, 1, the function value for out_vec.
REQ-013 The block SHALL have port busy, output, 1, high in RUN and DONE.
REQ-014 The block SHALL have port done, output, 1, a one-cycle pulse on sweep completion.
REQ-015 The block SHALL have port ones_count, output, N_IN+1, the number of transferred samples with out_f=1 in the current or last sweep.

Function
REQ-016 The FSM SHALL have states IDLE, RUN and DONE; all outputs SHALL be registered.
REQ-017 In IDLE, tt_load=1 SHALL capture tt_data into tt_reg; tt_load outside IDLE SHALL be ignored.
REQ-018 In IDLE, start=1 SHALL latch gray_mode, clear the index and ones_count, and enter RUN at the same edge.
REQ-019 If tt_load and start are both high in IDLE, the sweep SHALL use the newly loaded table.
REQ-020 start in RUN or DONE SHALL be ignored.
REQ-021 In RUN, out_valid SHALL be 1; out_vec SHALL be idx in binary mode or idx^(idx>>1) in Gray mode; out_f SHALL be tt_reg[out_vec].
REQ-022 Latency: the first sample SHALL appear with out_valid=1 in the cycle after the start edge.
REQ-023 A transfer SHALL occur on an edge with out_valid=1 and out_ready=1; idx SHALL increment and ones_count SHALL add out_f.
REQ-024 While out_valid=1 and out_ready=0, out_vec and out_f SHALL hold stable.
REQ-025 The transfer at idx=2**N_IN-1 SHALL move the FSM to DONE with out_valid=0; the index SHALL NOT wrap into another sweep.
REQ-026 DONE SHALL last exactly one cycle with done=1, then return to IDLE; ones_count SHALL hold until the next start.
REQ-027 abort=1 in RUN SHALL return the FSM to IDLE at the next edge with out_valid=0 and no done pulse; ones_count SHALL keep its partial value.
REQ-028 If abort and a final transfer coincide, abort SHALL win: no done pulse, and the final sample SHALL still be counted.
REQ-029 abort in IDLE or DONE SHALL have no effect.

Reset
REQ-030 rst_n=0 SHALL, asynchronously, force IDLE and set tt_reg, idx, out_valid, out_vec, out_f, busy, done and ones_count to 0.
REQ-031 Reset mid-sweep SHALL discard the sweep; after release the block SHALL be in IDLE and require tt_load and start again.

Configuration
REQ-032 With macro MINTERM_SWEEP_COUNT_EN defined, ones_count SHALL behave as specified; without it, ones_count SHALL be tied to 0 and its counter SHALL NOT be implemented.

Verification
REQ-033 The bench SHALL cover: N_IN=4, tt_data=16'hDF03, gray_mode=0, out_ready=1, start -> out_f sequence 1,1,0,0,0,0,0,0,1,1,1,1,1,0,1,1 for vectors 0..15, done one cycle after the last transfer, ones_count=9.
REQ-034 The bench SHALL cover: same table, gray_mode=1 -> out_vec 0,1,3,2,6,7,5,4,12,13,15,14,10,11,9,8, out_f 1,1,0,0,0,0,0,0,1,0,1,1,1,1,1,1, ones_count=9.
REQ-035 The bench SHALL cover: out_ready=0 for 3 cycles at vector 5 -> out_vec=5 and out_f held stable, no skipped or repeated vector, 16 transfers in total.
REQ-036 The bench SHALL cover: abort after 6 transfers -> IDLE next cycle, out_valid=0, no done, ones_count=2.
REQ-037 The bench SHALL cover: tt_load=1 with tt_data=16'hFFFF during RUN -> ignored, sweep keeps 16'hDF03 values; rst_n=0 mid-sweep -> all outputs 0 immediately, without waiting for a clock edge.
